// File: rtl/fetch_queue_stage.sv
// PC generator plus DEPTH-entry instruction queue feeding decode; request-to-head latency 2 cycles.
// Credit-based issue never overflows the queue; a full queue with id_ready=0 stalls fetch and holds the head.
module fetch_queue_stage #(
  parameter int unsigned     PC_W     = 9,
  parameter int unsigned     INS_W    = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [PC_W-1:0]  id_pc,
  output logic [INS_W-1:0] id_instr,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             halt,
  output logic             fetch_idle
);

  localparam int unsigned    PTR_W   = $clog2(DEPTH);
  localparam int unsigned    CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);
  localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PC_W-1:0]  mem_pc_q    [DEPTH];
  logic [INS_W-1:0] mem_instr_q [DEPTH];

  logic             pop;
  logic             push;
  logic [CNT_W:0]   occ;
  logic [PC_W-1:0]  tgt;

  assign id_pc    = mem_pc_q[rd_ptr_q];
  assign id_instr = mem_instr_q[rd_ptr_q];

  always_comb begin
    tgt      = redirect_pc & ~PC_W'(3);
    id_valid = (count_q != '0) & ~redirect & ~reset;
    pop      = id_valid & id_ready;
    push     = inflight_q & ~redirect & ~reset;
    // Slots already owed to the queue once this cycle's pop retires.
    occ      = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);

    imem_req  = 1'b0;
    imem_addr = pc_q;
    if (reset) begin
      imem_addr = RESET_PC;
    end else if (redirect) begin
      imem_req  = ~halt;
      imem_addr = tgt;
    end else begin
      imem_req  = ~halt & (occ < DEPTH_V);
    end

    fetch_idle = halt & (reset | ((count_q == '0) & ~inflight_q));

    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (redirect) begin
      count_d       = '0;
      rd_ptr_d      = wr_ptr_q;
      inflight_d    = ~halt;
      inflight_pc_d = tgt;
      pc_d          = halt ? tgt : tgt + PC_INC;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (imem_req) begin
        pc_d          = pc_q + PC_INC;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue storage carries no reset; entries are only observed through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
      mem_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: doc/fetch_queue_stage.md
# fetch_queue_stage

Parametrised instruction-fetch front end for the pipelined RISC-V core. It generalises the single PC register and IF/ID latch into a PC generator plus a DEPTH-entry instruction queue. Decode consumes instructions through a valid/ready handshake, so decode stalls no longer gate the PC directly. Execute-stage redirects (branch/jump) flush the queue and squash the in-flight memory response. Sits between instruction memory (synchronous, 1-cycle read) and the decode/register-file stage.

## Interface

Parameters:
- PC_W, 9: PC/address width; PC arithmetic is modulo 2^PC_W.
- INS_W, 32: instruction width.
- DEPTH, 4: queue entries; power of two, minimum 2.
- RESET_PC, 0: PC after reset; word aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- imem_req  out  1  read request to instruction memory this cycle.
- imem_addr  out  PC_W  read address; data is returned the following cycle.
- imem_rdata  in  INS_W  instruction for the address requested in the previous cycle.
- id_valid  out  1  queue head holds a valid instruction.
- id_ready  in  1  decode accepts the head this cycle.
- id_pc  out  PC_W  PC of the head entry.
- id_instr  out  INS_W  instruction of the head entry.
- redirect  in  1  flush and restart fetch at redirect_pc (from BranchUnit PcSel).
- redirect_pc  in  PC_W  target address; bits [1:0] are forced to 0.
- halt  in  1  level; suppresses new requests.
- fetch_idle  out  1  halt=1, queue empty, no request in flight.

## Operation

- State: pc, queue storage (pc+instr per entry), wr_ptr/rd_ptr of log2(DEPTH) bits, count of log2(DEPTH)+1 bits, inflight bit, inflight_pc.
- pop = id_valid & id_ready; id_valid = (count != 0) & !redirect.
- Normal issue: imem_req = !halt & !redirect-suppression & (count + inflight − pop) < DEPTH. imem_addr = pc. When a request is issued: pc <= pc + 4, inflight <= 1, inflight_pc <= pc. Otherwise inflight <= 0.
- Response: when inflight=1, {inflight_pc, imem_rdata} is pushed at wr_ptr at the end of that cycle. The credit rule guarantees no overflow, so push is never refused.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. The pc wraps modulo 2^PC_W (0x1FC + 4 → 0x000 for PC_W=9).
- Redirect (highest priority):
  - The queue is flushed: count <= 0 and rd_ptr <= wr_ptr.
  - The response of the in-flight request is discarded, not pushed.
  - id_valid = 0, so no pop occurs.
  - If halt=0: imem_req=1 with imem_addr = redirect_pc; then pc <= redirect_pc + 4 and inflight <= 1.
  - If halt=1: no request is issued; pc <= redirect_pc and inflight <= 0.
- Halt: no new requests are issued. The in-flight response is still pushed, and decode keeps draining the queue. Releasing halt resumes fetch at pc.
- Reset: pc <= RESET_PC; count, pointers and inflight cleared. Reset overrides redirect, halt and the handshake. A response in flight when reset is applied is dropped.

## Timing

- Output values during and immediately after reset:
  - id_valid=0.
  - imem_req=0 during the reset cycle, then 1 if halt=0.
  - imem_addr=RESET_PC.
  - fetch_idle = halt.
  - id_pc and id_instr are don't-care while id_valid=0.
- Fetch latency: a request issued in cycle t is pushed at the end of t+1 and is visible at id_valid/id_pc/id_instr in t+2.
- Redirect in cycle t: the target instruction appears at the head in t+2. Redirect penalty is therefore 2 bubbles, not counting wrong-path entries already in the queue.
- Throughput: 1 instruction/cycle sustained for DEPTH ≥ 2 when id_ready=1 continuously. The pop term makes imem_req combinationally dependent on id_ready.
- Outputs id_valid/id_pc/id_instr depend only on registered state, except that id_valid is masked by redirect.
- If id_ready=0 and the queue is full: imem_req=0, and the head and its contents are held stable.

## Test plan

- Reset then free run, DEPTH=4, id_ready=1: imem_addr 0,4,8,… one per cycle; id_pc 0 first valid at cycle 2 after reset release, then +4 every cycle with no gaps.
- Backpressure: id_ready=0 from cycle 0. The queue fills with PCs 0,4,8,0xC, imem_req drops to 0, and count=4 is held. Raising id_ready drains PCs in order and fetch resumes at 0x10 with no loss or duplicate.
- Redirect with a non-empty queue: at cycle with head 0x8 and inflight 0x14, pulse redirect, redirect_pc=0x43. imem_addr=0x40 that cycle, the 0x14 response is discarded, the next id_pc is 0x40 two cycles later, followed by 0x44.
- Halt: assert halt mid-stream. Exactly one more entry (the in-flight one) is pushed, the queue drains, and fetch_idle=1 once empty. Release halt: fetch resumes at the next sequential PC.
- Redirect while halted: redirect_pc=0x100 with halt=1 issues no request and fetch_idle stays 1. Release halt: imem_addr=0x100 is issued the next cycle.
- Wrap and reset: start near 0x1F8 via redirect. PCs go 0x1F8, 0x1FC, 0x000. Assert reset with the queue full and a request in flight: the following cycle id_valid=0, count=0, and imem_addr=RESET_PC.
